// File: rtl/p2s_serializer.sv
// p2s_serializer: parallel-to-serial transmitter feeding an s2p shift register.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
// MSB-first with load high for the data window. A one-cycle gap with load low
// and a done pulse follows each frame.
// Optional feature: define P2S_PARITY_EN to append an even-parity bit after
// the data bits. The load window then spans WIDTH+1 cycles.
module p2s_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serout,
  output logic             load,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef P2S_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
`ifdef P2S_PARITY_EN
  localparam logic [CW-1:0] CNT_DATA = CW'(WIDTH);
  logic             par;
`endif

  // Handshake and status decode straight from the state register
  assign din_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Frame sequencer: capture, shift, gap; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      serout <= 1'b0;
      load   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      shreg  <= '0;
`ifdef P2S_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (din_valid) begin
            shreg  <= din << 1;
            serout <= din[WIDTH-1];
            load   <= 1'b1;
            cnt    <= CW'(1);
            state  <= SHIFT;
`ifdef P2S_PARITY_EN
            par    <= ^din;
`endif
          end
        end
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            load   <= 1'b0;
            serout <= 1'b0;
            done   <= 1'b1;
            state  <= GAP;
          end
`ifdef P2S_PARITY_EN
          else if (cnt == CNT_DATA) begin
            serout <= par;
            cnt    <= cnt + 1'b1;
          end
`endif
          else begin
            serout <= shreg[WIDTH-1];
            shreg  <= shreg << 1;
            cnt    <= cnt + 1'b1;
          end
        end
        GAP: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Testbench for p2s_serializer: directed steps with a word scoreboard.
// Expected frames are queued when a word is driven, then dequeued and compared
// when the serial window closes.
module tb_p2s_serializer;

  localparam int unsigned W = 8;
`ifdef P2S_PARITY_EN
  localparam int unsigned FW = W + 1;
`else
  localparam int unsigned FW = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, serout, load, busy, done;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] sb[$];

  p2s_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .serout(serout), .load(load),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_word(input logic [W-1:0] w);
`ifdef P2S_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Monitor: collect serial bits while load is high, close frame when it drops
  logic [FW-1:0] cap = '0;
  int            nb  = 0;
  always @(negedge clk) begin
    logic end_now;
    if (rst) begin
      cap = '0;
      nb  = 0;
    end else begin
      end_now = (load === 1'b0) && (nb > 0);
      if (end_now || done === 1'b1)
        chk("done_pulse", {31'b0, done}, {31'b0, end_now});
      if (load === 1'b1) begin
        cap = {cap[FW-2:0], serout};
        nb++;
      end else if (end_now) begin
        chk("window_len", nb, FW);
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          chk("frame_word", cap, sb.pop_front());
        end
        nb = 0;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (din_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", {31'b0, t < 50}, 1);
  endtask

  task automatic send(input logic [W-1:0] w, input bit push);
    wait_ready();
    din = w;
    din_valid = 1'b1;
    if (push) sb.push_back(exp_word(w));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = $urandom;
    chk("accept_busy", {31'b0, busy}, 1);
    chk("accept_ready", {31'b0, din_ready}, 0);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Asynchronous reset between edges, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_serout", {31'b0, serout}, 0);
    chk("rst_load", {31'b0, load}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ready", {31'b0, din_ready}, 1);
    @(negedge clk);
    rst = 1'b0;

    // Single frame
    send(8'hA5, 1);
    wait_ready();

    // Back-to-back with din_valid held high
    begin
      int  cycles = 0;
      bit  sampled = 0;
      wait_ready();
      din = 8'h3C;
      din_valid = 1'b1;
      sb.push_back(exp_word(8'h3C));
      @(posedge clk);
      #1;
      din = 8'hC3;
      sb.push_back(exp_word(8'hC3));
      while (!sampled && cycles < 50) begin
        @(negedge clk);
        sampled = (din_ready === 1'b1);
        @(posedge clk);
        cycles++;
      end
      #1;
      din_valid = 1'b0;
      chk("b2b_spacing", cycles, FW + 2);
    end
    wait_ready();

    // din_valid during SHIFT must be ignored
    send(8'h00, 1);
    @(negedge clk);
    @(negedge clk);
    din = 8'hFF;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);
    chk("ignored_no_frame", {31'b0, busy}, 0);
    chk("ignored_sb_empty", sb.size(), 0);

    // Reset mid-frame after three bits
    send(8'hF0, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_load", {31'b0, load}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_serout", {31'b0, serout}, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done}, 0);
    end
    send(8'h81, 1);
    wait_ready();

    // Parity-sensitive words, then a few random words
    send(8'h07, 1);
    send(8'h03, 1);
    for (int i = 0; i < 4; i++) send(W'($urandom), 1);
    wait_ready();
    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
